ro_scan_controller: RTL

- Sequencer for the N-to-1 ring-oscillator select mux in the thermal sensor array.
- Drives the mux `select` through indices 0..NWAY-1 and waits a settle time after each switch.
- Counts rising edges of the muxed RO output over a fixed gate window and reports one count per RO on a valid/ready stream to the readout logic.
- Supports single-scan and continuous-scan modes.

---
 rtl/ro_scan_pkg.sv | 14 +
 rtl/ro_scan_controller_edge_counter.sv | 49 ++++
 rtl/ro_scan_controller.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/ro_scan_pkg.sv
// Shared types and widths for the ring-oscillator scan controller.
package ro_scan_pkg;

    localparam int unsigned SEL_W = 11;
    localparam int unsigned TS_W  = 32;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        GATE,
        REPORT
    } scan_state_e;

endpackage

// File: rtl/ro_scan_controller_edge_counter.sv
// ro_edge_counter: 2-flop synchronizer, rising-edge detect and a saturating
// edge counter with synchronous clear and count enable.
module ro_edge_counter #(
    parameter int unsigned CNT_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ro_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o
);

    logic             sync1_q;
    logic             sync2_q;
    logic             prev_q;
    logic             rise;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= ro_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            cnt_q   <= cnt_d;
        end
    end

    assign rise = sync2_q & ~prev_q;

    // Clear wins over counting; the count sticks at all-ones instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && rise && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/ro_scan_controller.sv
// Ring-oscillator scan sequencer: steps the mux select, settles, gates an edge
// count and streams one result per RO. Optional macro RO_SCAN_TIMESTAMP_EN adds sample_ts.
module ro_scan_controller
    import ro_scan_pkg::*;
#(
    parameter int unsigned NWAY          = 5,
    parameter int unsigned GATE_CYCLES   = 1024,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned CNT_W         = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             continuous,
    input  logic             ro_selected,
    output logic [SEL_W-1:0] select,
    output logic             busy,
    output logic             sample_valid,
    input  logic             sample_ready,
    output logic [SEL_W-1:0] sample_idx,
    output logic [CNT_W-1:0] sample_count,
`ifdef RO_SCAN_TIMESTAMP_EN
    output logic [TS_W-1:0]  sample_ts,
`endif
    output logic             scan_done
);

    if (NWAY < 1 || NWAY > 2048) begin : g_bad_nway
        $error("ro_scan_controller: NWAY must be in 1..2048");
    end
    if (GATE_CYCLES < 1) begin : g_bad_gate
        $error("ro_scan_controller: GATE_CYCLES must be >= 1");
    end
    if (SETTLE_CYCLES < 3) begin : g_bad_settle
        $error("ro_scan_controller: SETTLE_CYCLES must be >= 3");
    end

    localparam int unsigned TMAX  = (GATE_CYCLES >= SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int unsigned TMR_W = $clog2(TMAX + 1);

    scan_state_e      state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             sv_q, sv_d;
    logic [SEL_W-1:0] sidx_q, sidx_d;
    logic [CNT_W-1:0] scnt_q, scnt_d;
    logic             done_q, done_d;
    logic             cnt_clr;
    logic             cnt_en;
    logic [CNT_W-1:0] edge_count;

`ifdef RO_SCAN_TIMESTAMP_EN
    logic [TS_W-1:0]  ts_q;
    logic [TS_W-1:0]  sts_q, sts_d;
`endif

    ro_edge_counter #(
        .CNT_W (CNT_W)
    ) u_edge_counter (
        .clk     (clk),
        .rst     (rst),
        .ro_i    (ro_selected),
        .clr_i   (cnt_clr),
        .en_i    (cnt_en),
        .count_o (edge_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            sel_q   <= '0;
            sv_q    <= 1'b0;
            sidx_q  <= '0;
            scnt_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            sel_q   <= sel_d;
            sv_q    <= sv_d;
            sidx_q  <= sidx_d;
            scnt_q  <= scnt_d;
            done_q  <= done_d;
        end
    end

`ifdef RO_SCAN_TIMESTAMP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_q  <= '0;
            sts_q <= '0;
        end else begin
            ts_q  <= ts_q + TS_W'(1);
            sts_q <= sts_d;
        end
    end
`endif

    // GATE spans GATE_CYCLES counting cycles plus one capture cycle, so the
    // final gate cycle's edge lands in the counter before it is sampled.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        sel_d   = sel_q;
        sv_d    = sv_q;
        sidx_d  = sidx_q;
        scnt_d  = scnt_q;
        done_d  = 1'b0;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
`ifdef RO_SCAN_TIMESTAMP_EN
        sts_d   = sts_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sel_d   = '0;
                    timer_d = '0;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (timer_q == TMR_W'(SETTLE_CYCLES - 1)) begin
                    timer_d = '0;
                    cnt_clr = 1'b1;
                    state_d = GATE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            GATE: begin
                if (timer_q == TMR_W'(GATE_CYCLES)) begin
                    sv_d    = 1'b1;
                    sidx_d  = sel_q;
                    scnt_d  = edge_count;
`ifdef RO_SCAN_TIMESTAMP_EN
                    sts_d   = ts_q;
`endif
                    state_d = REPORT;
                end else begin
                    cnt_en  = 1'b1;
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            REPORT: begin
                if (sample_ready) begin
                    sv_d    = 1'b0;
                    timer_d = '0;
                    if (sel_q < SEL_W'(NWAY - 1)) begin
                        sel_d   = sel_q + SEL_W'(1);
                        state_d = SETTLE;
                    end else if (continuous) begin
                        sel_d   = '0;
                        state_d = SETTLE;
                    end else begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign select       = sel_q;
    assign busy         = (state_q != IDLE);
    assign sample_valid = sv_q;
    assign sample_idx   = sidx_q;
    assign sample_count = scnt_q;
    assign scan_done    = done_q;
`ifdef RO_SCAN_TIMESTAMP_EN
    assign sample_ts    = sts_q;
`endif

endmodule
